// File: rtl/prince_iter_core_if.sv
// Block-level valid/ready stream bundle between a PRINCE client and the iterative core.
// The core side uses the slave modport; the client side uses master.
interface prince_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic         in_dec;
    logic [63:0]  in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;

    modport master (
        output in_valid, in_dec, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_dec, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/prince_iter_core.sv
// Iterative PRINCE encrypt/decrypt core: one round per clock on a 64-bit state register.
// Nibble 0 is bits [63:60] throughout.
module prince_iter_core (
    input  logic              clk,
    input  logic              rst,
    prince_iter_core_if.slave bus
);
    localparam logic [63:0]  ALPHA      = 64'hc0ac29b7c97c50dd;
    localparam logic [63:0]  SBOX       = 64'hbf32ac916780e5d4;
    localparam logic [63:0]  SBOX_INV   = 64'hb732fd89a6405ec1;
    localparam logic [63:0]  SR_MAP     = 64'h05af49e38d27c16b;
    localparam logic [63:0]  SR_INV_MAP = 64'h0da741eb852fc963;
    // Columns of M^0 (column i in bits [16*i +: 16]); M^1 is the same set rotated by four columns.
    localparam logic [255:0] M0_COLS    =
        256'h0888_4044_2202_1110_8880_0444_2022_1101_8808_4440_0222_1011_8088_4404_2220_0111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t        fsm;
    logic [3:0]  rnd;
    logic [63:0] state;
    logic [63:0] wk_out;
    logic [63:0] kc;

    function automatic logic [3:0] nib(input logic [63:0] x, input int idx);
        return 4'(x >> (60 - 4 * idx));
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x, input logic inv);
        logic [63:0] tbl;
        logic [63:0] y;
        tbl = inv ? SBOX_INV : SBOX;
        y   = '0;
        for (int j = 0; j < 16; j++)
            y = (y << 4) | 64'(nib(tbl, int'(nib(x, j))));
        return y;
    endfunction

    // Output nibble j takes input nibble map(j).
    function automatic logic [63:0] permute(input logic [63:0] x, input logic [63:0] map);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 16; j++)
            y = (y << 4) | 64'(nib(x, int'(nib(map, j))));
        return y;
    endfunction

    function automatic logic [15:0] m_hat(input logic [15:0] x, input logic one);
        logic [15:0] v;
        logic [15:0] acc;
        int          k;
        v   = x;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            k = one ? (i + 12) % 16 : i;
            if (v[0])
                acc = acc ^ 16'(M0_COLS >> (16 * k));
            v = v >> 1;
        end
        return acc;
    endfunction

    function automatic logic [63:0] m_prime(input logic [63:0] x);
        return {m_hat(x[63:48], 1'b0), m_hat(x[47:32], 1'b1),
                m_hat(x[31:16], 1'b1), m_hat(x[15:0],  1'b0)};
    endfunction

    function automatic logic [63:0] rc(input logic [3:0] idx);
        case (idx)
            4'd1:    return 64'h13198a2e03707344;
            4'd2:    return 64'ha4093822299f31d0;
            4'd3:    return 64'h082efa98ec4e6c89;
            4'd4:    return 64'h452821e638d01377;
            4'd5:    return 64'hbe5466cf34e90c6c;
            4'd6:    return 64'h7ef84f78fd955cb1;
            4'd7:    return 64'h85840851f1ac43aa;
            4'd8:    return 64'hc882d32f25323c54;
            4'd9:    return 64'h64a51195e0e3610d;
            4'd10:   return 64'hd3b5a399ca0c2399;
            4'd11:   return 64'hc0ac29b7c97c50dd;
            default: return 64'h0;
        endcase
    endfunction

    logic [63:0] k0, k0_rot, k1;
    logic [63:0] mp_out, round_res;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path so no latch is inferred.
        round_res = '0;
        k0        = bus.in_key[127:64];
        k1        = bus.in_key[63:0];
        k0_rot    = {k0[0], k0[63:1]} ^ {63'b0, k0[63]};
        mp_out    = m_prime(s_layer(state, 1'b0));
        if (rnd <= 4'd5)
            round_res = permute(mp_out, SR_MAP) ^ rc(rnd) ^ kc;
        else if (rnd == 4'd6)
            round_res = s_layer(mp_out, 1'b1);
        else
            round_res = s_layer(m_prime(permute(state ^ kc ^ rc(rnd - 4'd1), SR_INV_MAP)), 1'b1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm           <= IDLE;
            rnd           <= '0;
            state         <= '0;
            wk_out        <= '0;
            kc            <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        state        <= bus.in_data ^ (bus.in_dec ? k0_rot : k0)
                                                    ^ (bus.in_dec ? (k1 ^ ALPHA) : k1);
                        wk_out       <= bus.in_dec ? k0 : k0_rot;
                        kc           <= bus.in_dec ? (k1 ^ ALPHA) : k1;
                        rnd          <= 4'd1;
                        bus.in_ready <= 1'b0;
                        fsm          <= BUSY;
                    end
                end
                BUSY: begin
                    rnd <= rnd + 4'd1;
                    if (rnd == 4'd11) begin
                        bus.out_data  <= round_res ^ rc(4'd11) ^ kc ^ wk_out;
                        bus.out_valid <= 1'b1;
                        fsm           <= DONE;
                    end else begin
                        state <= round_res;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        fsm           <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prince_iter_core.sv
// Self-checking bench for prince_iter_core: table of known PRINCE vectors plus
// backpressure and mid-operation reset sequences, checked through a scoreboard queue.
module tb_prince_iter_core;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prince_iter_core_if bus ();

    prince_iter_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic         dec;
        logic [63:0]  data;
        logic [127:0] key;
        logic [63:0]  exp;
    } vec_t;

    vec_t        vecs [10];
    logic [63:0] sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_block(input vec_t v, input string name);
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            step();
            n++;
        end
        check({name, " in_ready before accept"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_dec   = v.dec;
        bus.in_data  = v.data;
        bus.in_key   = v.key;
        step();
        sb.push_back(v.exp);
        // Scramble the inputs: the core must work from its captured copies.
        bus.in_valid = 1'b0;
        bus.in_dec   = ~v.dec;
        bus.in_data  = {$urandom(), $urandom()};
        bus.in_key   = {$urandom(), $urandom(), $urandom(), $urandom()};
        check({name, " in_ready after accept"}, 64'(bus.in_ready), 64'd0);
    endtask

    task automatic wait_out(input string name);
        int          lat = 0;
        logic [63:0] exp;
        while (!bus.out_valid && lat < 40) begin
            step();
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'd11);
        exp = '0;
        if (sb.size() != 0)
            exp = sb.pop_front();
        check({name, " out_data"}, bus.out_data, exp);
    endtask

    task automatic take(input string name);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({name, " out_valid after take"}, 64'(bus.out_valid), 64'd0);
        check({name, " in_ready after take"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic quiet(input string name, input int cycles);
        logic seen = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            step();
            seen = seen | bus.out_valid;
        end
        check({name, " no spurious out_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 64'h0000000000000000, 128'h0, 64'h818665aa0d02dfda};
        vecs[1] = '{1'b0, 64'hffffffffffffffff, 128'h0, 64'h604ae6ca03c20ada};
        vecs[2] = '{1'b0, 64'h0000000000000000, {64'hffffffffffffffff, 64'h0}, 64'h9fb51935fc3df524};
        vecs[3] = '{1'b0, 64'h0123456789abcdef, {64'h0, 64'hfedcba9876543210}, 64'hae25ad3ca8fa9ccf};
        vecs[4] = '{1'b0, 64'h0000000000000000, {64'h0, 64'hffffffffffffffff}, 64'h78a54cbe737bb7ef};
        vecs[5] = '{1'b1, 64'h818665aa0d02dfda, 128'h0, 64'h0000000000000000};
        vecs[6] = '{1'b1, 64'h78a54cbe737bb7ef, {64'h0, 64'hffffffffffffffff}, 64'h0000000000000000};
        vecs[7] = '{1'b1, 64'h604ae6ca03c20ada, 128'h0, 64'hffffffffffffffff};
        vecs[8] = '{1'b1, 64'h9fb51935fc3df524, {64'hffffffffffffffff, 64'h0}, 64'h0000000000000000};
        vecs[9] = '{1'b1, 64'hae25ad3ca8fa9ccf, {64'h0, 64'hfedcba9876543210}, 64'h0123456789abcdef};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_dec    = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_data", bus.out_data, 64'd0);
        rst = 1'b0;
        step();
        check("idle in_ready", 64'(bus.in_ready), 64'd1);

        for (int i = 0; i < 10; i++) begin
            string name;
            name = $sformatf("vec%0d", i);
            accept_block(vecs[i], name);
            wait_out(name);
            take(name);
        end

        // Backpressure: result held, in_ready low, new in_valid ignored.
        accept_block(vecs[3], "bp");
        wait_out("bp");
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom(), $urandom()};
            step();
            check($sformatf("bp hold%0d out_data", c), bus.out_data, vecs[3].exp);
            check($sformatf("bp hold%0d out_valid", c), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp hold%0d in_ready", c), 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        take("bp");
        quiet("bp after", 15);

        // Reset asserted while rnd = 4.
        accept_block(vecs[1], "rst");
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check("mid rst out_valid", 64'(bus.out_valid), 64'd0);
        check("mid rst in_ready", 64'(bus.in_ready), 64'd1);
        check("mid rst out_data", bus.out_data, 64'd0);
        sb.delete();
        step();
        rst = 1'b0;
        quiet("post rst", 15);

        accept_block(vecs[2], "after rst");
        wait_out("after rst");
        take("after rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
